// File: rtl/uart_echo_fifo_if.sv
// Serial lines and status of the UART echo block; master = the echo block, slave = its environment.
interface uart_echo_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             serialRX;
  logic             serialTX;
  logic             txHold;
  logic [CNT_W-1:0] fifoCount;
  logic             overflow;
  logic             frameErr;

  modport master (
    input  serialRX, txHold,
    output serialTX, fifoCount, overflow, frameErr
  );

  modport slave (
    output serialRX, txHold,
    input  serialTX, fifoCount, overflow, frameErr
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// UART echo: RX frame -> +ADD_VALUE -> FIFO -> TX; start bit 2 cycles after push; txHold stalls TX between frames only.
// Full FIFO drops the word and sets sticky overflow; UART_ECHO_OVFCNT_EN adds a saturating ovfCount port.
module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADD_VALUE    = 1
) (
  input  logic clk,
  input  logic rst,
  uart_echo_fifo_if.master bus
`ifdef UART_ECHO_OVFCNT_EN
  ,
  output logic [7:0] ovfCount
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  localparam logic [CW-1:0]        BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]        HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]        BITS_LAST = BW'(DATA_BITS - 1);
  localparam logic [NW-1:0]        DEPTH_N   = NW'(FIFO_DEPTH);
  localparam logic [DATA_BITS-1:0] ADD_W     = DATA_BITS'(ADD_VALUE);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [1:0]           warm_q, warm_d;
  logic                 armed_q, armed_d;
  state_t               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 frame_err_q, frame_err_d;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  state_t               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;

  logic                 push_req, push_ok, pop, full, drop;
  logic [DATA_BITS-1:0] push_word;

  always_comb begin
    rx_s1_d     = bus.serialRX;
    rx_s2_d     = rx_s1_q;
    // warm_q[1] marks that rx_s2_q now reflects the real line rather than reset values
    warm_d      = {warm_q[0], 1'b1};
    armed_d     = armed_q | (warm_q[1] & rx_s2_q);
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (armed_q && !rx_s2_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BITS_LAST) rx_state_d = S_STOP;
          else                       rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_s2_q) begin
            push_req = 1'b1;
          end else begin
            // a low stop bit leaves the line low; demand a fresh falling edge
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase

    push_word = rx_shift_q + ADD_W;
    full      = (count_q == DEPTH_N);
    pop       = (tx_state_q == S_IDLE) && (count_q != '0) && !bus.txHold;
    push_ok   = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    ovf_d     = ovf_q | drop;

    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (pop) begin
          tx_state_d = S_START;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BITS_LAST) begin
            tx_d       = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_bit_d   = tx_bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign bus.serialTX  = tx_q;
  assign bus.fifoCount = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.frameErr  = frame_err_q;

`ifdef UART_ECHO_OVFCNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_cnt_q <= '0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovfCount = ovf_cnt_q;
`endif

endmodule
